// File: rtl/scope_pkt_pkg.sv
// Shared constants and encodings for the scope UDP packer.
// SCOPE_PKT_CSUM_EN selects whether pkt_len() callers add the trailer.
package scope_pkt_pkg;

  localparam logic [7:0] HDR_MAGIC0    = 8'h55;
  localparam logic [7:0] HDR_MAGIC1    = 8'hAA;
  localparam int         HDR_LEN       = 6;
  localparam int         TRL_LEN       = 2;
  localparam int         FLAG_DROP_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_TRL
  } rd_state_e;

  typedef enum logic [1:0] {
    SRC_CONST,
    SRC_RAM,
    SRC_TRL_HI,
    SRC_TRL_LO
  } byte_src_e;

  function automatic logic [15:0] pkt_len(input int frame_len, input bit csum_en);
    return 16'(HDR_LEN + frame_len + (csum_en ? TRL_LEN : 0));
  endfunction

endpackage

// File: rtl/scope_pkt_dpram.sv
// Ping-pong frame buffer: one write port, one registered read port.
// The address MSB selects the bank.
module scope_pkt_dpram #(
  parameter int P_ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [P_ADDR_W:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic              i_rd_en,
  input  logic [P_ADDR_W:0] i_rd_addr,
  output logic [7:0]        o_rd_data
);

  logic [7:0] mem_q [2**(P_ADDR_W+1)];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= mem_q[i_rd_addr];
  end

endmodule

// File: rtl/scope_udp_packer.sv
// Buffers scope frames in a ping-pong RAM and replays them as header-prefixed packets.
// Define SCOPE_PKT_CSUM_EN to append a 16-bit payload sum trailer.
//
// state   | meaning
// IDLE    | waiting for the oldest bank to be full
// HDR     | issuing the 6 header bytes
// PAY     | issuing payload reads from the bank
// TRL     | issuing the 2 checksum bytes (checksum build only)
module scope_udp_packer
  import scope_pkt_pkg::*;
#(
  parameter int P_FRAME_LEN = 1008,
  parameter int P_ADDR_W    = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_show_ad_data,
  input  logic        i_show_ad_data_vld,
  input  logic        i_show_ad_data_last,
  output logic [7:0]  o_udp_tx_data,
  output logic        o_udp_tx_vld,
  output logic        o_udp_tx_last,
  input  logic        i_udp_tx_ready,
  output logic [15:0] o_udp_tx_len,
  output logic [15:0] o_drop_cnt,
  output logic [15:0] o_err_cnt
);

`ifdef SCOPE_PKT_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam logic [P_ADDR_W:0]   LEN_W    = (P_ADDR_W+1)'(P_FRAME_LEN);
  localparam logic [P_ADDR_W-1:0] LAST_IDX = P_ADDR_W'(P_FRAME_LEN - 1);
  localparam logic [P_ADDR_W-1:0] HDR_LAST = P_ADDR_W'(HDR_LEN - 1);
  localparam logic [15:0]         FLEN16   = 16'(P_FRAME_LEN);
  localparam logic [15:0]         TX_LEN   = pkt_len(P_FRAME_LEN, CSUM);

  // write side
  logic              wr_act_q, wr_skip_q, wr_skip_d, wr_bank_q;
  logic [P_ADDR_W:0] wr_cnt_q, wr_cnt_d, wr_idx;
  logic [1:0]        full_q, full_d;
  logic              drop_flag_q, drop_flag_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d, err_cnt_q, err_cnt_d;
  logic              frame_start, frame_close, frame_good, drop_ev, wr_en;

  // read side
  rd_state_e         state_q, state_d;
  logic [P_ADDR_W-1:0] idx_q, idx_d;
  logic              iss_done_q, iss_done_d, rd_bank_q;
  logic [7:0]        seq_q;
  logic [15:0]       len_q;
  logic              issue, iss_last, can_issue, out_fire, pkt_done;
  byte_src_e         iss_src, p_src_q;
  logic [7:0]        iss_byte, p_byte_q, p_data, ram_rdata, flags;
  logic              p_vld_q, p_last_q;
  logic [1:0]        fcnt_q, fcnt_d;
  logic [8:0]        f0_q, f0_d, f1_q, f1_d;

  always_comb begin
    frame_start = i_show_ad_data_vld && !wr_act_q;
    frame_close = wr_act_q && !i_show_ad_data_vld;
    drop_ev     = frame_start && full_q[wr_bank_q];
    frame_good  = frame_close && !wr_skip_q && (wr_cnt_q == LEN_W) && i_show_ad_data_last;
    wr_idx      = frame_start ? '0 : wr_cnt_q;
    wr_en       = i_show_ad_data_vld && (frame_start ? !drop_ev : !wr_skip_q) && (wr_idx < LEN_W);
    wr_skip_d   = frame_start ? drop_ev : wr_skip_q;
    wr_cnt_d    = wr_cnt_q;
    if (frame_start) wr_cnt_d = (P_ADDR_W+1)'(1);
    else if (i_show_ad_data_vld && wr_cnt_q <= LEN_W) wr_cnt_d = wr_cnt_q + (P_ADDR_W+1)'(1);
    // Completion and frame close may hit different banks in the same cycle.
    full_d = full_q;
    if (pkt_done) full_d[rd_bank_q] = 1'b0;
    if (frame_good) full_d[wr_bank_q] = 1'b1;
    drop_flag_d = drop_ev ? 1'b1 : (pkt_done ? 1'b0 : drop_flag_q);
    drop_cnt_d = drop_cnt_q;
    if (drop_ev && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    err_cnt_d = err_cnt_q;
    if (frame_close && !wr_skip_q && !frame_good && err_cnt_q != 16'hFFFF)
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_act_q    <= 1'b0;
      wr_skip_q   <= 1'b0;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      full_q      <= '0;
      drop_flag_q <= 1'b0;
      drop_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      wr_act_q    <= i_show_ad_data_vld;
      wr_skip_q   <= wr_skip_d;
      wr_bank_q   <= wr_bank_q ^ frame_good;
      wr_cnt_q    <= wr_cnt_d;
      full_q      <= full_d;
      drop_flag_q <= drop_flag_d;
      drop_cnt_q  <= drop_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  scope_pkt_dpram #(.P_ADDR_W(P_ADDR_W)) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (wr_en),
    .i_wr_addr ({wr_bank_q, wr_idx[P_ADDR_W-1:0]}),
    .i_wr_data (i_show_ad_data),
    .i_rd_en   (issue && (iss_src == SRC_RAM)),
    .i_rd_addr ({rd_bank_q, idx_q}),
    .o_rd_data (ram_rdata)
  );

  // Issue only if the skid still has room once the in-flight RAM read lands.
  assign out_fire  = o_udp_tx_vld && i_udp_tx_ready;
  assign can_issue = ({1'b0, fcnt_q} + {2'b00, p_vld_q} - {2'b00, out_fire}) <= 3'd1;
  assign pkt_done  = out_fire && o_udp_tx_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      iss_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      iss_done_q <= iss_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    iss_done_d = iss_done_q;
    case (state_q)
      ST_IDLE: if (issue) begin
        state_d = ST_HDR;
        idx_d   = P_ADDR_W'(1);
      end
      ST_HDR: if (issue) begin
        if (idx_q == HDR_LAST) begin
          state_d = ST_PAY;
          idx_d   = '0;
        end else idx_d = idx_q + P_ADDR_W'(1);
      end
      ST_PAY: if (issue) begin
        if (idx_q == LAST_IDX) begin
`ifdef SCOPE_PKT_CSUM_EN
          state_d = ST_TRL;
          idx_d   = '0;
`else
          iss_done_d = 1'b1;
`endif
        end else idx_d = idx_q + P_ADDR_W'(1);
      end
`ifdef SCOPE_PKT_CSUM_EN
      ST_TRL: if (issue) begin
        if (idx_q[0]) iss_done_d = 1'b1;
        else idx_d = idx_q + P_ADDR_W'(1);
      end
`endif
      default: ;
    endcase
    if (pkt_done) begin
      state_d    = ST_IDLE;
      idx_d      = '0;
      iss_done_d = 1'b0;
    end
  end

  always_comb begin
    issue    = 1'b0;
    iss_src  = SRC_CONST;
    iss_byte = '0;
    iss_last = 1'b0;
    flags    = '0;
    flags[FLAG_DROP_BIT] = drop_flag_q;
    case (state_q)
      ST_IDLE: begin
        issue    = can_issue && full_q[rd_bank_q];
        iss_byte = HDR_MAGIC0;
      end
      ST_HDR: begin
        issue = can_issue;
        case (idx_q[2:0])
          3'd1:    iss_byte = HDR_MAGIC1;
          3'd2:    iss_byte = seq_q;
          3'd3:    iss_byte = flags;
          3'd4:    iss_byte = FLEN16[15:8];
          3'd5:    iss_byte = FLEN16[7:0];
          default: iss_byte = HDR_MAGIC0;
        endcase
      end
      ST_PAY: begin
        issue    = can_issue && !iss_done_q;
        iss_src  = SRC_RAM;
        iss_last = !CSUM && (idx_q == LAST_IDX);
      end
`ifdef SCOPE_PKT_CSUM_EN
      ST_TRL: begin
        issue    = can_issue && !iss_done_q;
        iss_src  = idx_q[0] ? SRC_TRL_LO : SRC_TRL_HI;
        iss_last = idx_q[0];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_bank_q <= 1'b0;
      seq_q     <= '0;
      len_q     <= '0;
      p_vld_q   <= 1'b0;
      p_src_q   <= SRC_CONST;
      p_byte_q  <= '0;
      p_last_q  <= 1'b0;
      fcnt_q    <= '0;
      f0_q      <= '0;
      f1_q      <= '0;
    end else begin
      if (pkt_done) begin
        rd_bank_q <= ~rd_bank_q;
        seq_q     <= seq_q + 8'd1;
      end
      if (state_q == ST_IDLE && issue) len_q <= TX_LEN;
      p_vld_q  <= issue;
      p_src_q  <= iss_src;
      p_byte_q <= iss_byte;
      p_last_q <= iss_last;
      fcnt_q   <= fcnt_d;
      f0_q     <= f0_d;
      f1_q     <= f1_d;
    end
  end

`ifdef SCOPE_PKT_CSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sum_q <= '0;
    else if (state_q == ST_IDLE && issue) sum_q <= '0;
    else if (p_vld_q && p_src_q == SRC_RAM) sum_q <= sum_q + {8'h00, ram_rdata};
  end
`endif

  // Trailer bytes resolve one cycle after issue, once the last payload byte is summed.
  always_comb begin
    p_data = p_byte_q;
    case (p_src_q)
      SRC_RAM:    p_data = ram_rdata;
`ifdef SCOPE_PKT_CSUM_EN
      SRC_TRL_HI: p_data = sum_q[15:8];
      SRC_TRL_LO: p_data = sum_q[7:0];
`endif
      default: ;
    endcase
  end

  always_comb begin
    fcnt_d = fcnt_q;
    f0_d   = f0_q;
    f1_d   = f1_q;
    case ({p_vld_q, out_fire})
      2'b10: begin
        if (fcnt_q == 2'd0) f0_d = {p_last_q, p_data};
        else f1_d = {p_last_q, p_data};
        fcnt_d = fcnt_q + 2'd1;
      end
      2'b01: begin
        f0_d   = f1_q;
        fcnt_d = fcnt_q - 2'd1;
      end
      2'b11: begin
        if (fcnt_q == 2'd1) f0_d = {p_last_q, p_data};
        else begin
          f0_d = f1_q;
          f1_d = {p_last_q, p_data};
        end
      end
      default: ;
    endcase
  end

  assign o_udp_tx_vld  = (fcnt_q != 2'd0);
  assign o_udp_tx_data = f0_q[7:0];
  assign o_udp_tx_last = f0_q[8] && o_udp_tx_vld;
  assign o_udp_tx_len  = len_q;
  assign o_drop_cnt    = drop_cnt_q;
  assign o_err_cnt     = err_cnt_q;

endmodule
